// File: rtl/chan_packet_ctrl_decode.sv
// Stability-filters the software control word and decodes packetizer controls; CTRL_READBACK_EN adds status_out.
// Latency: a held word commits STABLE_CYCLES+2 cycles after it steps; no backpressure, length changes wait for pkt_sof.
`timescale 1ns/1ps
module chan_packet_ctrl_decode #(
  parameter int STABLE_CYCLES = 4,
  parameter int RST_STRETCH   = 8,
  parameter int MIN_LEN       = 16,
  parameter int MAX_LEN       = 1024
) (
  input  logic        user_clk,
  input  logic        user_rst,
  input  logic [31:0] user_data_in,
  input  logic        pkt_sof,
  output logic        run_en,
  output logic [7:0]  chan_sel,
  output logic [15:0] pkt_len,
  output logic        len_pending,
  output logic        soft_rst,
  output logic        arm_strobe,
  output logic        cfg_update
`ifdef CTRL_READBACK_EN
  ,
  output logic [31:0] status_out
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COMMIT
  } state_t;

  localparam logic [7:0]  CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]  STRETCH  = 8'(RST_STRETCH);
  localparam logic [15:0] LEN_MIN  = 16'(MIN_LEN);
  localparam logic [15:0] LEN_MAX  = 16'(MAX_LEN);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [31:0] s1, s2, shadow;
  logic        commit;
  logic [15:0] len_clamped;
  logic [15:0] len_hold;
  logic        arm_rise, srst_rise;
  logic [7:0]  rst_cnt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (s1 != shadow) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        // A revert to the committed value abandons the candidate outright.
        if (s1 == shadow) begin
          state_nxt = ST_IDLE;
        end else if (s1 != s2) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_COMMIT;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_COMMIT: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign commit    = (state == ST_COMMIT);
  assign arm_rise  = ~shadow[2] & s2[2];
  assign srst_rise = ~shadow[1] & s2[1];

  always_comb begin
    len_clamped = s2[31:16];
    if (s2[31:16] < LEN_MIN) begin
      len_clamped = LEN_MIN;
    end else if (s2[31:16] > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      s1     <= '0;
      s2     <= '0;
      state  <= ST_IDLE;
      cnt    <= '0;
      shadow <= '0;
    end else begin
      s1    <= user_data_in;
      s2    <= s1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (commit) begin
        shadow <= s2;
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      run_en     <= 1'b0;
      chan_sel   <= '0;
      cfg_update <= 1'b0;
      arm_strobe <= 1'b0;
    end else begin
      cfg_update <= commit;
      arm_strobe <= commit & arm_rise;
      if (commit) begin
        run_en   <= s2[0];
        chan_sel <= s2[15:8];
      end
    end
  end

  // While running, a new length is parked until the next packet boundary.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      pkt_len     <= LEN_MIN;
      len_hold    <= LEN_MIN;
      len_pending <= 1'b0;
    end else if (commit) begin
      if (!s2[0]) begin
        pkt_len     <= len_clamped;
        len_pending <= 1'b0;
      end else if (len_clamped != pkt_len) begin
        len_hold    <= len_clamped;
        len_pending <= 1'b1;
      end else begin
        len_pending <= 1'b0;
      end
    end else if (len_pending && pkt_sof) begin
      pkt_len     <= len_hold;
      len_pending <= 1'b0;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      rst_cnt <= '0;
    end else if (commit && srst_rise) begin
      rst_cnt <= STRETCH;
    end else if (rst_cnt != 8'd0) begin
      rst_cnt <= rst_cnt - 8'd1;
    end
  end

  assign soft_rst = (rst_cnt != 8'd0);

`ifdef CTRL_READBACK_EN
  logic [15:0] commit_cnt;

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      commit_cnt <= '0;
      status_out <= '0;
    end else begin
      if (commit) begin
        commit_cnt <= commit_cnt + 16'd1;
      end
      status_out <= {commit_cnt, 6'd0, len_pending, run_en, chan_sel};
    end
  end
`endif

endmodule
